dll_ctrl_multi: RTL

//  Multi-lane synthesizable DLL delay controller, successor to the single-lane behavioural DLL model.
//  Per lane: drives the tap code io_adj to a delay line and closes the loop on a bang-bang phase-detector bit.

---
 rtl/dll_ctrl_multi.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dll_ctrl_multi.sv
// dll_ctrl_multi: per-lane bang-bang DLL tap controller with auto tracking and manual code pass-through.
// state  | meaning
// HOLD   | just restarted; adj = init code, picks TRACK or MANUAL next cycle
// TRACK  | steps adj on the phase detector every SETTLE cycles, counting reversals
// LOCKED | dithering around the edge; lock held until three same-direction steps
// MANUAL | adj follows the clamped software code; lock after LOCK_WAIT unchanged cycles
module dll_ctrl_multi #(
    parameter int LANES     = 4,
    parameter int AW        = 8,
    parameter int MADJ      = 128,
    parameter int SETTLE    = 16,
    parameter int REV_LOCK  = 4,
    parameter int LOCK_WAIT = 100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_mode,
    input  logic [LANES-1:0]    io_dll_reset,
    input  logic [AW-1:0]       io_init_adj,
    input  logic [LANES*AW-1:0] io_man_adj,
    input  logic [LANES-1:0]    io_pd_early,
    output logic [LANES*AW-1:0] io_adj,
    output logic [AW-1:0]       io_madj,
    output logic [LANES-1:0]    io_lock,
    output logic                io_lock_all,
    output logic [LANES-1:0]    io_err
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int RW = $clog2(REV_LOCK + 1);
    localparam int SW = $clog2(LOCK_WAIT + 1);
    localparam logic [AW-1:0] ADJ_MAX  = AW'(MADJ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [RW-1:0] REV_TGT  = RW'(REV_LOCK);
    localparam logic [SW-1:0] STB_TGT  = SW'(LOCK_WAIT);

    typedef enum logic [1:0] {HOLD, TRACK, LOCKED, MANUAL} state_t;

    logic          mode_q;
    logic [AW-1:0] init_clamped;

    always_ff @(posedge clock) begin
        mode_q <= io_mode;
    end

    assign init_clamped = (io_init_adj > ADJ_MAX) ? ADJ_MAX : io_init_adj;
    assign io_madj      = AW'(MADJ);
    assign io_lock_all  = &io_lock;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_t        state, state_nxt;
        logic [AW-1:0] adj, adj_nxt, man;
        logic          lock, lock_nxt;
        logic          err, err_nxt;
        logic          dir, dir_nxt;
        logic          stepped, stepped_nxt;
        logic [RW-1:0] rev, rev_nxt;
        logic [1:0]    same, same_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic [SW-1:0] stable, stable_nxt;
        logic          restart, up;

        assign restart = io_dll_reset[i] | (io_mode != mode_q);
        assign up      = io_pd_early[i];
        assign man     = (io_man_adj[i*AW +: AW] > ADJ_MAX) ? ADJ_MAX : io_man_adj[i*AW +: AW];

        always_comb begin
            state_nxt   = state;
            adj_nxt     = adj;
            lock_nxt    = lock;
            err_nxt     = err;
            dir_nxt     = dir;
            stepped_nxt = stepped;
            rev_nxt     = rev;
            same_nxt    = same;
            cnt_nxt     = cnt;
            stable_nxt  = stable;
            if (restart) begin
                state_nxt   = HOLD;
                adj_nxt     = init_clamped;
                lock_nxt    = 1'b0;
                err_nxt     = 1'b0;
                dir_nxt     = 1'b0;
                stepped_nxt = 1'b0;
                rev_nxt     = '0;
                same_nxt    = '0;
                cnt_nxt     = '0;
                stable_nxt  = '0;
            end else begin
                case (state)
                    HOLD: begin
                        if (io_mode) begin
                            state_nxt  = MANUAL;
                            adj_nxt    = man;
                            stable_nxt = '0;
                        end else begin
                            state_nxt = TRACK;
                        end
                    end
                    TRACK, LOCKED: begin
                        if (cnt != CNT_LAST) begin
                            cnt_nxt = cnt + 1'b1;
                        end else begin
                            cnt_nxt = '0;
                            // a clamped step still counts as a step for reversal tracking
                            if ((up && adj == ADJ_MAX) || (!up && adj == '0))
                                err_nxt = 1'b1;
                            else
                                adj_nxt = up ? adj + 1'b1 : adj - 1'b1;
                            if (stepped && (up != dir)) begin
                                same_nxt = '0;
                                if (rev != REV_TGT) rev_nxt = rev + 1'b1;
                            end else if (same != 2'd3) begin
                                same_nxt = same + 2'd1;
                            end
                            dir_nxt     = up;
                            stepped_nxt = 1'b1;
                            if (state == TRACK && rev_nxt == REV_TGT) begin
                                state_nxt = LOCKED;
                                lock_nxt  = 1'b1;
                            end else if (state == LOCKED && same_nxt == 2'd3) begin
                                state_nxt = TRACK;
                                lock_nxt  = 1'b0;
                                rev_nxt   = '0;
                            end
                        end
                    end
                    MANUAL: begin
                        if (man != adj) begin
                            adj_nxt    = man;
                            stable_nxt = '0;
                            lock_nxt   = 1'b0;
                        end else begin
                            if (stable != STB_TGT) stable_nxt = stable + 1'b1;
                            if (stable_nxt == STB_TGT) lock_nxt = 1'b1;
                        end
                    end
                    default: state_nxt = HOLD;
                endcase
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state   <= HOLD;
                adj     <= init_clamped;
                lock    <= 1'b0;
                err     <= 1'b0;
                dir     <= 1'b0;
                stepped <= 1'b0;
                rev     <= '0;
                same    <= '0;
                cnt     <= '0;
                stable  <= '0;
            end else begin
                state   <= state_nxt;
                adj     <= adj_nxt;
                lock    <= lock_nxt;
                err     <= err_nxt;
                dir     <= dir_nxt;
                stepped <= stepped_nxt;
                rev     <= rev_nxt;
                same    <= same_nxt;
                cnt     <= cnt_nxt;
                stable  <= stable_nxt;
            end
        end

        assign io_adj[i*AW +: AW] = adj;
        assign io_lock[i]         = lock;
        assign io_err[i]          = err;
    end
endmodule
